// File: rtl/redun_mont_collapse_if.sv
// Handshake bundle for the redundant-to-canonical collapse stage:
// redundant operand in, canonical Montgomery-domain result out.
interface redun_mont_collapse_if #(
    parameter int NUM_WRDS = 65,
    parameter int WRD_BITS = 16
);
    logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat;
    logic                             i_val;
    logic                             o_rdy;
    logic [NUM_WRDS*WRD_BITS-1:0]     o_dat;
    logic                             o_ovf;
    logic                             o_val;
    logic                             i_rdy;

    // master drives the operand and accepts the result (host side)
    modport master (
        output i_dat, i_val, i_rdy,
        input  o_rdy, o_dat, o_ovf, o_val
    );

    modport slave (
        input  i_dat, i_val, i_rdy,
        output o_rdy, o_dat, o_ovf, o_val
    );
endinterface

// File: rtl/redun_mont_collapse.sv
// Word-serial carry ripple of a redundant Montgomery result followed by up to
// MAX_SUB conditional subtractions of P, giving a canonical value in [0, P).
module redun_mont_collapse #(
    parameter int                           NUM_WRDS = 65,
    parameter int                           WRD_BITS = 16,
    parameter logic [NUM_WRDS*WRD_BITS-1:0] P        = '1,
    parameter int                           MAX_SUB  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    redun_mont_collapse_if.slave bus
);

    localparam int LW     = NUM_WRDS * WRD_BITS;
    localparam int IW     = NUM_WRDS * (WRD_BITS + 1);
    localparam int IDX_W  = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
    localparam int PASS_W = $clog2(MAX_SUB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CARRY,
        S_SUB,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       in_q;
    logic [LW-1:0]       acc_lo_q;
    logic [1:0]          acc_top_q;
    logic [LW-1:0]       diff_q;
    logic [1:0]          carry_q;
    logic                borrow_q;
    logic [IDX_W-1:0]    wrd_idx_q;
    logic [PASS_W-1:0]   pass_q;
    logic                rdy_q;
    logic                val_q;
    logic                ovf_q;

    logic [WRD_BITS+1:0] sum;
    logic [WRD_BITS-1:0] p_wrd;
    logic [WRD_BITS:0]   diff;
    logic [2:0]          top_diff;
    logic                last_wrd;

    // The word being processed always sits at the bottom of in_q / acc_lo_q;
    // acc_lo_q rotates once per SUB pass so it returns to its original order.
    always_comb begin
        sum      = (WRD_BITS+2)'(in_q[WRD_BITS:0]) + (WRD_BITS+2)'(carry_q);
        p_wrd    = P[wrd_idx_q*WRD_BITS +: WRD_BITS];
        diff     = {1'b0, acc_lo_q[WRD_BITS-1:0]} - {1'b0, p_wrd} - (WRD_BITS+1)'(borrow_q);
        top_diff = {1'b0, acc_top_q} - 3'(diff[WRD_BITS]);
        last_wrd = (wrd_idx_q == IDX_W'(NUM_WRDS - 1));
    end

    // NOTE: every register here, datapath included, is reset so an aborted
    // operation leaves no stale value visible on o_dat; all state updates use
    // non-blocking assignments so each word step sees the previous edge's values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            in_q      <= '0;
            acc_lo_q  <= '0;
            acc_top_q <= '0;
            diff_q    <= '0;
            carry_q   <= '0;
            borrow_q  <= 1'b0;
            wrd_idx_q <= '0;
            pass_q    <= '0;
            rdy_q     <= 1'b1;
            val_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_val && rdy_q) begin
                        in_q      <= bus.i_dat;
                        carry_q   <= '0;
                        wrd_idx_q <= '0;
                        rdy_q     <= 1'b0;
                        state_q   <= S_CARRY;
                    end
                end

                S_CARRY: begin
                    in_q     <= in_q >> (WRD_BITS + 1);
                    acc_lo_q <= {sum[WRD_BITS-1:0], acc_lo_q[LW-1:WRD_BITS]};
                    carry_q  <= sum[WRD_BITS+1:WRD_BITS];
                    if (last_wrd) begin
                        acc_top_q <= sum[WRD_BITS+1:WRD_BITS];
                        wrd_idx_q <= '0;
                        pass_q    <= '0;
                        borrow_q  <= 1'b0;
                        state_q   <= S_SUB;
                    end else begin
                        wrd_idx_q <= wrd_idx_q + IDX_W'(1);
                    end
                end

                S_SUB: begin
                    acc_lo_q <= {acc_lo_q[WRD_BITS-1:0], acc_lo_q[LW-1:WRD_BITS]};
                    diff_q   <= {diff[WRD_BITS-1:0], diff_q[LW-1:WRD_BITS]};
                    borrow_q <= diff[WRD_BITS];
                    if (last_wrd) begin
                        wrd_idx_q <= '0;
                        borrow_q  <= 1'b0;
                        if (top_diff[2]) begin
                            ovf_q   <= 1'b0;
                            val_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (pass_q < PASS_W'(MAX_SUB)) begin
                            // Commit the full difference, including this last word.
                            acc_lo_q  <= {diff[WRD_BITS-1:0], diff_q[LW-1:WRD_BITS]};
                            acc_top_q <= top_diff[1:0];
                            pass_q    <= pass_q + PASS_W'(1);
                        end else begin
                            ovf_q   <= 1'b1;
                            val_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        wrd_idx_q <= wrd_idx_q + IDX_W'(1);
                    end
                end

                S_DONE: begin
                    if (bus.i_rdy) begin
                        val_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_rdy = rdy_q;
    assign bus.o_val = val_q;
    assign bus.o_ovf = ovf_q;
    assign bus.o_dat = acc_lo_q;

endmodule
